// File: rtl/board_mem_arbiter.sv
// Round-robin arbiter and sequencer that serves N_RD strided burst-read clients and one writer
// on a single-port, strobe-clocked board-cell memory.
module board_mem_arbiter #(
    parameter int CELL_W  = 2,
    parameter int ADDR_W  = 6,
    parameter int BURST   = 7,
    parameter int N_RD    = 2,
    parameter int WR_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_RD-1:0]         rd_req,
    input  logic [N_RD*ADDR_W-1:0]  rd_addr,
    input  logic [N_RD*ADDR_W-1:0]  rd_stride,
    output logic [BURST*CELL_W-1:0] rd_data,
    output logic [N_RD-1:0]         rd_done,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [CELL_W-1:0]       wr_data,
    output logic                    wr_done,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rden,
    output logic                    mem_wren,
    output logic                    mem_clk,
    output logic [CELL_W-1:0]       mem_wdata,
    input  logic [CELL_W-1:0]       mem_rdata
);

    localparam int ID_W = $clog2(N_RD + 1);
    localparam int K_W  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int H_W  = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [K_W-1:0]  K_LAST  = K_W'(BURST - 1);
    localparam logic [H_W-1:0]  H_LAST  = H_W'(WR_HOLD - 1);
    localparam logic [ID_W-1:0] WR_ID   = ID_W'(N_RD);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STROBE, RD_CAPT, RD_DONE, WR_SETUP, WR_STROBE, WR_FADE
    } state_t;

    state_t            state, state_next;
    logic [K_W-1:0]    k;
    logic [H_W-1:0]    hold_cnt;
    logic [ID_W-1:0]   rr_ptr, id_q, grant_idx;
    logic              grant_valid;
    logic [ADDR_W-1:0] cur_addr, stride_q;
    logic [CELL_W-1:0] wdata_q;
    logic [N_RD:0]     req_all;

    assign req_all = {wr_req, rd_req};

    // First requester at or after rr_ptr, searching cyclically over reads then the writer.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off <= N_RD; off++) begin
            int idx;
            idx = (int'(rr_ptr) + off) % (N_RD + 1);
            if (!grant_valid && req_all[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (grant_valid) state_next = (grant_idx == WR_ID) ? WR_SETUP : RD_SETUP;
            RD_SETUP:  state_next = RD_STROBE;
            RD_STROBE: state_next = RD_CAPT;
            RD_CAPT:   state_next = (k == K_LAST) ? RD_DONE : RD_SETUP;
            RD_DONE:   state_next = IDLE;
            WR_SETUP:  state_next = WR_STROBE;
            WR_STROBE: if (hold_cnt == H_LAST) state_next = WR_FADE;
            WR_FADE:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // cur_addr walks base + k*stride by accumulation; it also carries the write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            id_q     <= '0;
            cur_addr <= '0;
            stride_q <= '0;
            wdata_q  <= '0;
            rd_data  <= '0;
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    id_q   <= grant_idx;
                    rr_ptr <= (grant_idx == WR_ID) ? '0 : grant_idx + 1'b1;
                    k      <= '0;
                    if (grant_idx == WR_ID) begin
                        cur_addr <= wr_addr;
                        wdata_q  <= wr_data;
                    end else begin
                        cur_addr <= rd_addr[grant_idx*ADDR_W +: ADDR_W];
                        stride_q <= rd_stride[grant_idx*ADDR_W +: ADDR_W];
                    end
                end
                RD_CAPT: begin
                    rd_data[k*CELL_W +: CELL_W] <= mem_rdata;
                    if (k != K_LAST) begin
                        k        <= k + 1'b1;
                        cur_addr <= cur_addr + stride_q;
                    end
                end
                RD_DONE:   k        <= '0;
                WR_SETUP:  hold_cnt <= '0;
                WR_STROBE: hold_cnt <= hold_cnt + 1'b1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_clk   = 1'b0;
        mem_wdata = '0;
        wr_done   = 1'b0;
        rd_done   = '0;
        case (state)
            RD_SETUP, RD_STROBE, RD_CAPT: begin
                mem_addr = cur_addr;
                mem_rden = 1'b1;
                mem_clk  = (state == RD_STROBE);
            end
            WR_SETUP, WR_STROBE, WR_FADE: begin
                mem_addr  = cur_addr;
                mem_wren  = 1'b1;
                mem_wdata = wdata_q;
                mem_clk   = (state == WR_STROBE);
                wr_done   = (state == WR_FADE);
            end
            RD_DONE: begin
                for (int i = 0; i < N_RD; i++)
                    if (id_q == ID_W'(i)) rd_done[i] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a strobe-clocked memory model and per-scenario tasks.
module tb_board_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_req;
    logic [11:0] rd_addr, rd_stride;
    logic [13:0] rd_data;
    logic [1:0]  rd_done;
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        wr_done, busy;
    logic [5:0]  mem_addr;
    logic        mem_rden, mem_wren, mem_clk;
    logic [1:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [1:0] mem [64];
    logic [5:0] addr_log [$];
    logic       overlap_seen = 1'b0;

    always #5 clk = ~clk;

    board_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_stride(rd_stride),
        .rd_data(rd_data), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .busy(busy),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_clk(mem_clk), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory acts on the rising edge of its strobe; read data is registered.
    always @(posedge mem_clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        if (mem_rden) begin
            mem_rdata <= mem[mem_addr];
            addr_log.push_back(mem_addr);
        end
    end

    always @(posedge clk) if (mem_rden && mem_wren) overlap_seen = 1'b1;

    task automatic run_read(input int c, input logic [5:0] base, input logic [5:0] stride,
                            input int drop_after, output logic [13:0] data, output int lat,
                            output logic [1:0] done_seen, output logic [1:0] done_next);
        @(negedge clk);
        addr_log.delete();
        rd_addr[c*6 +: 6]   = base;
        rd_stride[c*6 +: 6] = stride;
        rd_req[c]           = 1'b1;
        lat = 0;
        done_seen = 2'b00;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == drop_after) rd_req[c] = 1'b0;
            if (rd_done != 2'b00) begin
                lat = n;
                done_seen = rd_done;
                break;
            end
        end
        rd_req[c] = 1'b0;
        data = rd_data;
        @(posedge clk); #1;
        done_next = rd_done;
    endtask

    task automatic check_addrs(input string name, input logic [5:0] exp_a [7]);
        checks++;
        if (addr_log.size() !== 7) begin
            errors++;
            $display("FAIL %s addr count: got %0d expected 7", name, addr_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (addr_log[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, addr_log[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, rd_done, wr_done, mem_addr, mem_rden, mem_wren, mem_clk, mem_wdata, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b rd_done=%b mem_addr=%0d rd_data=%h expected all 0",
                     busy, rd_done, mem_addr, rd_data);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_burst_read();
        logic [13:0] d; int lat; logic [1:0] ds, dn;
        logic [5:0] exp_a [7];
        exp_a = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
        run_read(0, 6'd0, 6'd1, 0, d, lat, ds, dn);
        checks++;
        if (lat !== 22) begin errors++; $display("FAIL t1 latency: got %0d expected 22", lat); end
        checks++;
        if (ds !== 2'b01) begin errors++; $display("FAIL t1 rd_done: got %b expected 01", ds); end
        checks++;
        if (dn !== 2'b00) begin errors++; $display("FAIL t1 done width: got %b expected 00", dn); end
        checks++;
        if (d !== 14'b10_01_00_11_10_01_00) begin
            errors++; $display("FAIL t1 rd_data: got %b expected 10010011100100", d);
        end
        check_addrs("t1", exp_a);
    endtask

    task automatic test_stride_and_drop();
        logic [13:0] d; int lat; logic [1:0] ds, dn;
        logic [5:0] exp_a [7];
        exp_a = '{6'd3, 6'd10, 6'd17, 6'd24, 6'd31, 6'd38, 6'd45};
        run_read(1, 6'd3, 6'd7, 5, d, lat, ds, dn);
        checks++;
        if (ds !== 2'b10 || lat !== 22) begin
            errors++; $display("FAIL t2 done after drop: got %b at %0d expected 10 at 22", ds, lat);
        end
        checks++;
        if (d !== 14'b01_10_11_00_01_10_11) begin
            errors++; $display("FAIL t2 rd_data: got %b expected 01101100011011", d);
        end
        check_addrs("t2", exp_a);
    endtask

    task automatic test_wrap();
        logic [13:0] d; int lat; logic [1:0] ds, dn;
        logic [5:0] exp_a [7];
        exp_a = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2};
        run_read(0, 6'd60, 6'd1, 0, d, lat, ds, dn);
        checks++;
        if (d !== 14'b10_01_00_11_10_01_00) begin
            errors++; $display("FAIL t3 rd_data: got %b expected 10010011100100", d);
        end
        check_addrs("t3", exp_a);
    endtask

    task automatic test_write();
        logic [13:0] d; int lat; logic [1:0] ds, dn;
        logic [6:0] exp_bus [5];
        logic [6:0] got;
        // {mem_clk, mem_wren, mem_rden, wr_done, busy, mem_wdata==2, mem_addr==17} per cycle after grant
        exp_bus = '{7'b0100111, 7'b1100111, 7'b1100111, 7'b0101111, 7'b0000000};
        @(negedge clk);
        wr_addr = 6'd17; wr_data = 2'b10; wr_req = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (n == 3) wr_req = 1'b0;
            got = {mem_clk, mem_wren, mem_rden, wr_done, busy, mem_wdata == 2'b10, mem_addr == 6'd17};
            checks++;
            if (got !== exp_bus[n]) begin
                errors++; $display("FAIL t5 write cycle %0d: got %b expected %b", n + 1, got, exp_bus[n]);
            end
        end
        run_read(0, 6'd17, 6'd0, 0, d, lat, ds, dn);
        checks++;
        if (d !== 14'b10_10_10_10_10_10_10 || lat !== 22) begin
            errors++; $display("FAIL t5 readback stride0: got %b lat %0d expected 10101010101010 lat 22", d, lat);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [13:0] d; int lat; logic [1:0] ds, dn;
        logic       spurious;
        @(negedge clk);
        rd_addr[5:0] = 6'd0; rd_stride[5:0] = 6'd1; rd_req[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (mem_clk !== 1'b1 || mem_addr !== 6'd3) begin
            errors++; $display("FAIL t6 pre-reset phase: mem_clk=%b addr=%0d expected 1 and 3", mem_clk, mem_addr);
        end
        reset = 1'b1;
        rd_req[0] = 1'b0;
        #1;
        checks++;
        if ({busy, rd_done, mem_addr, mem_rden, mem_clk, rd_data} !== '0) begin
            errors++; $display("FAIL t6 async reset: busy=%b mem_clk=%b addr=%0d rd_data=%h expected 0",
                               busy, mem_clk, mem_addr, rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
        spurious = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rd_done !== 2'b00 || busy !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin errors++; $display("FAIL t6 done after reset: got activity expected none"); end
        run_read(1, 6'd5, 6'd2, 0, d, lat, ds, dn);
        checks++;
        if (d !== 14'b10_11_01_11_01_11_01 || ds !== 2'b10 || lat !== 22) begin
            errors++; $display("FAIL t6 fresh read: got %b done %b lat %0d expected 10110111011101 10 22", d, ds, lat);
        end
    endtask

    task automatic test_round_robin();
        int got [$];
        int exp_order [6];
        int waited;
        exp_order = '{0, 1, 2, 0, 1, 2};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_addr = '0; rd_stride = {6'd1, 6'd1};
        wr_addr = 6'd20; wr_data = 2'b00;
        rd_req = 2'b11; wr_req = 1'b1;
        for (int n = 0; n < 2000 && got.size() < 6; n++) begin
            @(posedge clk); #1;
            if (rd_done[0]) got.push_back(0);
            if (rd_done[1]) got.push_back(1);
            if (wr_done)    got.push_back(2);
        end
        rd_req = 2'b00; wr_req = 1'b0;
        checks++;
        if (got.size() !== 6) begin errors++; $display("FAIL t4 grant count: got %0d expected 6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] !== exp_order[i]) begin
                errors++; $display("FAIL t4 grant[%0d]: got %0d expected %0d", i, got[i], exp_order[i]);
            end
        end
        waited = 0;
        while (busy && waited < 100) begin @(posedge clk); #1; waited++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t4 drain: busy=%b expected 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 2'(i % 4);
        mem_rdata = 2'b00;
        rd_req = '0; rd_addr = '0; rd_stride = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_burst_read();
        test_stride_and_drop();
        test_wrap();
        test_write();
        test_reset_mid_read();
        test_round_robin();
        checks++;
        if (overlap_seen !== 1'b0) begin errors++; $display("FAIL rden/wren overlap: got 1 expected 0"); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
